// File: rtl/uart_rx_bridge.sv
// UART receiver with a small byte FIFO toward the Wrapper.
// Define UART_RX_PARITY_EN for 8E1 framing; the default build is 8N1.
module uart_rx_bridge #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] UART_RX,
    output logic       UART_RX_valid,
    input  logic       UART_RX_ack,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic [1:0]       settle;
    logic             armed;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    logic fall, bit_tick, half_tick;
    logic cnt_clr, shift_en, push_req, frame_evt;
    logic full, pop, push_ok, overrun_evt;
`ifdef UART_RX_PARITY_EN
    logic parity_evt, par_bad;
`endif

    assign fall      = rx_prev & ~rx_sync;
    assign bit_tick  = (clk_cnt == BIT_LAST);
    assign half_tick = (clk_cnt == HALF_LAST);

    assign full        = (count == FULL_CNT);
    assign pop         = UART_RX_ack & UART_RX_valid;
    assign push_ok     = push_req & (~full | pop);
    assign overrun_evt = push_req & full & ~pop;

    assign UART_RX_valid = (count != '0);
    assign UART_RX       = UART_RX_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_evt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (armed && fall) begin
                    state_n = START;
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                if (half_tick) begin
                    cnt_clr = 1'b1;
                    state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_clr    = 1'b1;
                    parity_evt = (rx_sync != ^shift);
                    state_n    = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_n = IDLE;
                    if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Clearing 'armed' on a bad stop bit makes IDLE ignore the line until it idles high again.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            settle    <= '0;
            armed     <= 1'b0;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            settle  <= {settle[0], 1'b1};
            if (frame_evt)                armed <= 1'b0;
            else if (settle[1] && rx_sync) armed <= 1'b1;

            clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
            if (state == IDLE && cnt_clr) bit_idx <= '0;
            else if (shift_en)            bit_idx <= bit_idx + 3'd1;
            if (shift_en) shift <= {rx_sync, shift[7:1]};

            frame_err <= frame_evt;
            overrun   <= overrun_evt;

            if (push_ok) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_evt;
            if (parity_evt)         par_bad <= 1'b1;
            else if (state == IDLE) par_bad <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_bridge.sv
// Directed bench for uart_rx_bridge at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Follows UART_RX_PARITY_EN to switch between 8N1 and 8E1 framing.
`timescale 1ns/1ps
module tb_uart_rx_bridge;

`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Negedge index within a frame just before the stop-sample edge.
    localparam int STOP_I = 16 * (NB - 1) + 10;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RX;
    logic       UART_RX_ack;
    logic [7:0] UART_RX;
    logic       UART_RX_valid;
    logic       frame_err, parity_err, overrun;

    uart_rx_bridge #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .RX(RX),
        .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid), .UART_RX_ack(UART_RX_ack),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    logic v_pre, v_post;

    always @(posedge CLK) begin
        if (frame_err)  n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if (overrun)    n_ovr  <= n_ovr + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        int         exp_ferr;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic ack_pulse();
        UART_RX_ack = 1'b1;
        @(negedge CLK);
        UART_RX_ack = 1'b0;
        @(negedge CLK);
    endtask

    // Drives one full frame from the current negedge; ack_at raises ack for one cycle at that bit-cycle index.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int ack_at);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, d, 1'b0};
`else
        bits = {par, stop, d, 1'b0};
`endif
        for (int i = 0; i < NB * 16; i++) begin
            if (i == STOP_I)     v_pre  = UART_RX_valid;
            if (i == STOP_I + 1) v_post = UART_RX_valid;
            RX          = bits[i / 16];
            UART_RX_ack = (i == ack_at);
            @(negedge CLK);
        end
        RX          = 1'b1;
        UART_RX_ack = 1'b0;
    endtask

    initial begin
        int f0, o0;
        logic [7:0] b;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 1};
        vecs[2] = '{8'h11, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 0};
        vecs[5] = '{8'hFE, 1'b1, 1'b1, 0};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1};
        vecs[7] = '{8'h55, 1'b1, 1'b1, 0};

        RESET = 1'b1; RX = 1'b1; UART_RX_ack = 1'b0;
        idle(3);
        check("rst_valid", UART_RX_valid, 0);
        check("rst_data", UART_RX, 8'h00);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ovr", overrun, 0);
        RESET = 1'b0;
        idle(5);

        // Basic byte with exact push latency
        send_frame(8'hA5, 1'b1, ^8'hA5, -1);
        check("lat_before_push", v_pre, 0);
        check("lat_after_push", v_post, 1);
        idle(4);
        check("basic_valid", UART_RX_valid, 1);
        check("basic_data", UART_RX, 8'hA5);
        ack_pulse();
        check("basic_popped", UART_RX_valid, 0);
        ack_pulse();
        check("ack_when_empty", UART_RX_valid, 0);

        // Start glitch
        f0 = n_ferr;
        RX = 1'b0;
        idle(5);
        RX = 1'b1;
        idle(40);
        check("glitch_no_push", UART_RX_valid, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        for (int i = 0; i < 8; i++) begin
            f0 = n_ferr;
            o0 = n_ovr;
            send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data, -1);
            idle(4);
            check($sformatf("vec%0d_valid", i), UART_RX_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr - o0, 0);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), UART_RX, vecs[i].data);
                ack_pulse();
                check($sformatf("vec%0d_pop", i), UART_RX_valid, 0);
            end
        end

        // Overrun on the fifth back-to-back byte
        o0 = n_ovr;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, ^b, -1);
        end
        idle(4);
        check("ovr_pulse", n_ovr - o0, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_pop%0d", i), UART_RX, 8'(i));
            ack_pulse();
        end
        check("ovr_empty", UART_RX_valid, 0);

        // Full FIFO with ack on the push cycle
        o0 = n_ovr;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, ^b, (i == 5) ? STOP_I : -1);
        end
        idle(4);
        check("simul_no_ovr", n_ovr - o0, 0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("simul_pop%0d", i), UART_RX, 8'(i));
            ack_pulse();
        end
        check("simul_empty", UART_RX_valid, 0);

        // Reset during D3 of 0xFF with a byte already buffered
        send_frame(8'hC3, 1'b1, ^8'hC3, -1);
        idle(4);
        check("pre_rst_valid", UART_RX_valid, 1);
        f0 = n_ferr;
        RX = 1'b0;
        idle(16);
        RX = 1'b1;
        idle(16 * 3 + 8);
        RESET = 1'b1;
        #1;
        check("midrst_valid", UART_RX_valid, 0);
        check("midrst_data", UART_RX, 8'h00);
        idle(3);
        RESET = 1'b0;
        idle(120);
        check("midrst_no_ferr", n_ferr - f0, 0);
        check("midrst_no_push", UART_RX_valid, 0);
        send_frame(8'h5A, 1'b1, ^8'h5A, -1);
        idle(4);
        check("post_rst_valid", UART_RX_valid, 1);
        check("post_rst_data", UART_RX, 8'h5A);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        f0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(4);
        check("par_ok_valid", UART_RX_valid, 1);
        check("par_ok_data", UART_RX, 8'h07);
        check("par_ok_noerr", n_perr - f0, 0);
        ack_pulse();
        f0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(4);
        check("par_bad_nopush", UART_RX_valid, 0);
        check("par_bad_pulse", n_perr - f0, 1);
`else
        check("perr_tied", n_perr, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
